// File: rtl/ssg_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ssg_pkg
//  Description : Shared constants for the 7-segment scan controller:
//                active-low segment patterns (bit order g..a) and the scan
//                FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ssg_pkg;

    // Active-low segment patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/ssg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : ssg_scan_ctrl_if
//  Description : Load handshake between the BCD digit producer (master) and
//                the scan controller (slave).
//  Signals     : digits_in  4*NUM_DIGITS  BCD value, nibble 0 = LSD
//                dp_in      NUM_DIGITS    decimal points, 1 = lit
//                blank_lz   1             suppress leading zeros
//                load       1             1-cycle capture request
//                load_ack   1             pending value moved into shadow
//  Revision    : 1.0  initial release
// ============================================================================
interface ssg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic                    load;
    logic                    load_ack;

    modport master (
        output digits_in, dp_in, blank_lz, load,
        input  load_ack
    );

    modport slave (
        input  digits_in, dp_in, blank_lz, load,
        output load_ack
    );
endinterface
`default_nettype wire

// File: rtl/ssg_bcd_decode.sv
`default_nettype none
// ============================================================================
//  Module      : ssg_bcd_decode
//  Description : Combinational BCD nibble to active-low 7-segment decoder.
//                Non-BCD nibbles (10..15) and a set blank input both give
//                an all-off pattern.
//  Ports       : nibble  in  4  BCD digit
//                blank   in  1  force all segments off
//                seg     out 7  segments g..a, active-low
//  Revision    : 1.0  initial release
// ============================================================================
module ssg_bcd_decode
    import ssg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ssg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ssg_scan_ctrl
//  Description : Round-robin scan controller for a shared 7-segment bus.
//                Each digit slot is a blanking gap followed by a drive
//                period. Loaded values are held in a pending register and
//                moved into the display shadow only at frame boundaries.
//  Ports       : clk          in   system clock
//                reset        in   asynchronous, active-low reset
//                bus          slave load handshake (ssg_scan_ctrl_if)
//                frame_start  out  pulse on first cycle of a new frame
//                SSG_D        out  segments g..a, active-low
//                SSG_DP       out  decimal point, active-low
//                SSG_EN       out  digit enables, active-low
//  Revision    : 1.0  initial release
// ============================================================================
module ssg_scan_ctrl
    import ssg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                  clk,
    input  logic                  reset,
    ssg_scan_ctrl_if.slave        bus,
    output logic                  frame_start,
    output logic [6:0]            SSG_D,
    output logic                  SSG_DP,
    output logic [NUM_DIGITS-1:0] SSG_EN
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] c_blank_last = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] c_drive_last = CW'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [IW-1:0] c_idx_last   = IW'(NUM_DIGITS - 1);

    // ---------------- scan FSM ----------------
    scan_state_t   r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [IW-1:0] r_idx, w_idx_nx;
    logic          w_boundary;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BLANK;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + 1'b1;
        w_idx_nx   = r_idx;
        w_boundary = 1'b0;
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == c_blank_last) begin
                    w_state_nx = ST_DRIVE;
                    w_cnt_nx   = '0;
                end
            end
            ST_DRIVE: begin
                if (r_cnt == c_drive_last) begin
                    w_state_nx = ST_BLANK;
                    w_cnt_nx   = '0;
                    if (r_idx == c_idx_last) begin
                        // last drive cycle of the last digit: frame boundary
                        w_idx_nx   = '0;
                        w_boundary = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- pending / shadow registers ----------------
    logic [4*NUM_DIGITS-1:0] r_pend_digits, r_sh_digits;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_sh_dp;
    logic                    r_pend_blz, r_sh_blz;
    logic                    r_pend_v;
    logic                    r_load_ack;
    logic                    r_frame_start;
    logic                    r_started;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_digits <= '0;
            r_pend_dp     <= '0;
            r_pend_blz    <= 1'b0;
            r_pend_v      <= 1'b0;
            r_sh_digits   <= '0;
            r_sh_dp       <= '0;
            r_sh_blz      <= 1'b0;
            r_load_ack    <= 1'b0;
            r_frame_start <= 1'b0;
            r_started     <= 1'b0;
        end else begin
            r_load_ack    <= w_boundary && (r_pend_v || bus.load);
            // r_started makes the first frame after reset release announce itself
            r_frame_start <= w_boundary || !r_started;
            r_started     <= 1'b1;
            if (w_boundary) begin
                // a load landing on the boundary itself skips the pending stage
                if (bus.load) begin
                    r_sh_digits <= bus.digits_in;
                    r_sh_dp     <= bus.dp_in;
                    r_sh_blz    <= bus.blank_lz;
                end else if (r_pend_v) begin
                    r_sh_digits <= r_pend_digits;
                    r_sh_dp     <= r_pend_dp;
                    r_sh_blz    <= r_pend_blz;
                end
                r_pend_v <= 1'b0;
            end else if (bus.load) begin
                r_pend_digits <= bus.digits_in;
                r_pend_dp     <= bus.dp_in;
                r_pend_blz    <= bus.blank_lz;
                r_pend_v      <= 1'b1;
            end
        end
    end

    assign bus.load_ack = r_load_ack;
    assign frame_start  = r_frame_start;

    // ---------------- digit select and leading-zero mask ----------------
    logic [3:0] w_nib;
    logic       w_dp;
    logic       w_zero_run;
    logic       w_lz_sel;
    logic       w_blank;
    logic [6:0] w_seg;
    logic [NUM_DIGITS-1:0] w_en_drive;

    always_comb begin
        w_nib      = 4'd0;
        w_dp       = 1'b0;
        w_lz_sel   = 1'b0;
        w_zero_run = 1'b1;
        // walk from the MSD down: w_zero_run is set while every nibble so far is 0
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_sh_digits[4*i +: 4] == 4'd0);
            if (IW'(i) == r_idx) begin
                w_nib    = r_sh_digits[4*i +: 4];
                w_dp     = r_sh_dp[i];
                w_lz_sel = w_zero_run;
            end
        end
    end

    assign w_blank    = r_sh_blz && (r_idx != '0) && w_lz_sel;
    assign w_en_drive = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx);

    ssg_bcd_decode u_dec (
        .nibble (w_nib),
        .blank  (w_blank),
        .seg    (w_seg)
    );

    // ---------------- registered pin outputs ----------------
    logic [6:0]            r_ssg_d;
    logic                  r_ssg_dp;
    logic [NUM_DIGITS-1:0] r_ssg_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ssg_d  <= SEG_BLANK;
            r_ssg_dp <= 1'b1;
            r_ssg_en <= '1;
        end else if (r_state == ST_DRIVE) begin
            r_ssg_d  <= w_seg;
            r_ssg_dp <= ~w_dp;
            r_ssg_en <= w_en_drive;
        end else begin
            r_ssg_d  <= SEG_BLANK;
            r_ssg_dp <= 1'b1;
            r_ssg_en <= '1;
        end
    end

    assign SSG_D  = r_ssg_d;
    assign SSG_DP = r_ssg_dp;
    assign SSG_EN = r_ssg_en;

endmodule
`default_nettype wire
